// File: rtl/mem_access_unit.sv
// mem_access_unit
// ---------------
// Memory-access pipeline stage between EX/MEM and WB. It handles all
// RV32I/RV64I load and store widths. It generates byte enables and lane-shifts
// store data. Load data is sign- or zero-extended. Each RAM access uses a
// request/acknowledge handshake that stalls upstream until it completes. A
// configurable acknowledge timeout turns a missing ack into a bus error. Every
// write-back output is registered.
//
// Optional feature macro: MEM_MISALIGN_TRAP_EN
//   defined   : misaligned half/word/dword accesses are rejected without a RAM
//               request; a one-cycle misalign pulse is raised with the write-back.
//   undefined : misalign is tied low; address bits below the access size are
//               ignored, so every access is naturally aligned.
//
// Parameters: XLEN (32|64), ADDR_W (byte address width),
//             ACK_TIMEOUT (max ack wait cycles, 0 = never time out).
//
// Ports:
//   clk, reset            clock (rising edge), asynchronous active-high reset
//   valid_in / ready_out  upstream handshake (~ready_out stalls EX/MEM)
//   mem_op_in, funct3_in  operation class and RISC-V width/sign field
//   rd_addr_in, rd_we_in, rd_data_in          destination and ALU result
//   mem_addr_in, store_data_in                effective address, store data
//   ram_req/we/addr/be/wdata, ram_ack/rdata   RAM request/acknowledge bus
//   wb_valid, wb_rd_addr, wb_rd_we, wb_rd_data   registered write-back
//   bus_err, misalign     single-cycle error pulses
module mem_access_unit #(
    parameter int XLEN        = 32,
    parameter int ADDR_W      = 32,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                valid_in,
    output logic                ready_out,
    input  logic [1:0]          mem_op_in,
    input  logic [2:0]          funct3_in,
    input  logic [4:0]          rd_addr_in,
    input  logic                rd_we_in,
    input  logic [XLEN-1:0]     rd_data_in,
    input  logic [ADDR_W-1:0]   mem_addr_in,
    input  logic [XLEN-1:0]     store_data_in,
    output logic                ram_req,
    output logic                ram_we,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic [XLEN/8-1:0]   ram_be,
    output logic [XLEN-1:0]     ram_wdata,
    input  logic                ram_ack,
    input  logic [XLEN-1:0]     ram_rdata,
    output logic                wb_valid,
    output logic [4:0]          wb_rd_addr,
    output logic                wb_rd_we,
    output logic [XLEN-1:0]     wb_rd_data,
    output logic                bus_err,
    output logic                misalign
);
    localparam int NB    = XLEN / 8;
    localparam int LW    = $clog2(NB);
    localparam int CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);

    typedef enum logic {IDLE, ACCESS} state_t;
    state_t state_q, state_d;

    logic [CNT_W-1:0]  cnt_q;
    logic              ram_we_q;
    logic [ADDR_W-1:0] ram_addr_q;
    logic [NB-1:0]     ram_be_q;
    logic [XLEN-1:0]   ram_wdata_q;
    logic [2:0]        funct3_q;
    logic [LW-1:0]     lane_q;
    logic [4:0]        rd_addr_q;
    logic              rd_we_q;
    logic              wb_valid_q, wb_rd_we_q, bus_err_q;
    logic [4:0]        wb_rd_addr_q;
    logic [XLEN-1:0]   wb_rd_data_q;

    // ---------------- request decode ----------------
    logic          accept, is_mem, is_store, illegal_in, misaligned_in, start_access, timeout_hit;
    logic [LW-1:0] lane_raw, lane_in;
    logic [NB-1:0] size_mask;

    assign ready_out = (state_q == IDLE);
    assign accept    = valid_in & ready_out;
    assign is_mem    = (mem_op_in == 2'b01) | (mem_op_in == 2'b10);
    assign is_store  = (mem_op_in == 2'b10);
    assign illegal_in = ((funct3_in[1:0] == 2'b11) && (XLEN == 32)) ||
                        (funct3_in == 3'b111) ||
                        (is_store && (funct3_in[2:1] == 2'b11));
    assign lane_raw  = mem_addr_in[LW-1:0];

    // Lane rounded down to the access size (natural alignment) and the
    // matching byte-enable mask before shifting.
    always_comb begin
        lane_in   = lane_raw;
        size_mask = NB'(1);
        case (funct3_in[1:0])
            2'b00: begin lane_in = lane_raw;               size_mask = NB'(1);   end
            2'b01: begin lane_in = lane_raw & ~LW'(1);     size_mask = NB'(3);   end
            2'b10: begin lane_in = lane_raw & ~LW'(3);     size_mask = NB'(15);  end
            default: begin lane_in = lane_raw & ~LW'(7);   size_mask = NB'(255); end
        endcase
    end

`ifdef MEM_MISALIGN_TRAP_EN
    assign misaligned_in = is_mem & ~illegal_in & (lane_raw != lane_in);
`else
    assign misaligned_in = 1'b0;
`endif

    assign start_access = accept & is_mem & ~illegal_in & ~misaligned_in;
    assign timeout_hit  = (ACK_TIMEOUT != 0) && (cnt_q == CNT_LAST);

    // ---------------- load data extraction ----------------
    // Shift the addressed lane down. Push the access-sized field to the top,
    // then shift it back (arithmetic or logical) to extend it to XLEN.
    logic [XLEN-1:0] rdata_sh, rdata_top, load_data;
    logic [6:0]      shamt;

    always_comb begin
        shamt = 7'd0;
        case (funct3_q[1:0])
            2'b00:   shamt = 7'(XLEN - 8);
            2'b01:   shamt = 7'(XLEN - 16);
            2'b10:   shamt = 7'(XLEN - 32);
            default: shamt = 7'd0;
        endcase
        rdata_sh  = ram_rdata >> {lane_q, 3'b000};
        rdata_top = rdata_sh << shamt;
        load_data = funct3_q[2] ? (rdata_top >> shamt)
                                : $unsigned($signed(rdata_top) >>> shamt);
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_access) state_d = ACCESS;
            ACCESS:  if (ram_ack || timeout_hit) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q        <= '0;
            ram_we_q     <= 1'b0;
            ram_addr_q   <= '0;
            ram_be_q     <= '0;
            ram_wdata_q  <= '0;
            funct3_q     <= '0;
            lane_q       <= '0;
            rd_addr_q    <= '0;
            rd_we_q      <= 1'b0;
            wb_valid_q   <= 1'b0;
            wb_rd_addr_q <= '0;
            wb_rd_we_q   <= 1'b0;
            wb_rd_data_q <= '0;
            bus_err_q    <= 1'b0;
        end else begin
            wb_valid_q <= 1'b0;
            bus_err_q  <= 1'b0;
            if (state_q == IDLE) begin
                if (start_access) begin
                    // RAM-facing fields are computed once here, so they stay
                    // stable for as long as ram_req is held.
                    cnt_q       <= '0;
                    ram_we_q    <= is_store;
                    ram_addr_q  <= {mem_addr_in[ADDR_W-1:LW], LW'(0)};
                    ram_be_q    <= size_mask << lane_in;
                    ram_wdata_q <= store_data_in << {lane_in, 3'b000};
                    funct3_q    <= funct3_in;
                    lane_q      <= lane_in;
                    rd_addr_q   <= rd_addr_in;
                    rd_we_q     <= rd_we_in;
                end else if (accept) begin
                    // ALU pass-through, illegal width or trapped misalignment
                    wb_valid_q   <= 1'b1;
                    wb_rd_addr_q <= rd_addr_in;
                    wb_rd_we_q   <= is_mem ? 1'b0 : rd_we_in;
                    wb_rd_data_q <= is_mem ? '0 : rd_data_in;
                end
            end else begin
                if (ram_ack) begin
                    wb_valid_q   <= 1'b1;
                    wb_rd_addr_q <= rd_addr_q;
                    wb_rd_we_q   <= ram_we_q ? 1'b0 : rd_we_q;
                    wb_rd_data_q <= ram_we_q ? '0 : load_data;
                end else if (timeout_hit) begin
                    wb_valid_q   <= 1'b1;
                    bus_err_q    <= 1'b1;
                    wb_rd_addr_q <= rd_addr_q;
                    wb_rd_we_q   <= 1'b0;
                    wb_rd_data_q <= '0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

`ifdef MEM_MISALIGN_TRAP_EN
    logic misalign_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) misalign_q <= 1'b0;
        else       misalign_q <= accept & misaligned_in;
    end
    assign misalign = misalign_q;
`else
    assign misalign = 1'b0;
`endif

    assign ram_req    = (state_q == ACCESS);
    assign ram_we     = ram_we_q;
    assign ram_addr   = ram_addr_q;
    assign ram_be     = ram_be_q;
    assign ram_wdata  = ram_wdata_q;
    assign wb_valid   = wb_valid_q;
    assign wb_rd_addr = wb_rd_addr_q;
    assign wb_rd_we   = wb_rd_we_q;
    assign wb_rd_data = wb_rd_data_q;
    assign bus_err    = bus_err_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit (XLEN=32, ACK_TIMEOUT=4).
// Transactions are checked against a behavioural model of the load/store rules.
module tb_mem_access_unit;
    localparam int XLEN   = 32;
    localparam int ADDR_W = 32;
    localparam int TO     = 4;
    localparam int NB     = XLEN / 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              valid_in, ready_out;
    logic [1:0]        mem_op_in;
    logic [2:0]        funct3_in;
    logic [4:0]        rd_addr_in;
    logic              rd_we_in;
    logic [XLEN-1:0]   rd_data_in, store_data_in;
    logic [ADDR_W-1:0] mem_addr_in;
    logic              ram_req, ram_we, ram_ack;
    logic [ADDR_W-1:0] ram_addr;
    logic [NB-1:0]     ram_be;
    logic [XLEN-1:0]   ram_wdata, ram_rdata;
    logic              wb_valid, wb_rd_we, bus_err, misalign;
    logic [4:0]        wb_rd_addr;
    logic [XLEN-1:0]   wb_rd_data;

    mem_access_unit #(.XLEN(XLEN), .ADDR_W(ADDR_W), .ACK_TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .ready_out(ready_out),
        .mem_op_in(mem_op_in), .funct3_in(funct3_in), .rd_addr_in(rd_addr_in),
        .rd_we_in(rd_we_in), .rd_data_in(rd_data_in), .mem_addr_in(mem_addr_in),
        .store_data_in(store_data_in), .ram_req(ram_req), .ram_we(ram_we),
        .ram_addr(ram_addr), .ram_be(ram_be), .ram_wdata(ram_wdata),
        .ram_ack(ram_ack), .ram_rdata(ram_rdata), .wb_valid(wb_valid),
        .wb_rd_addr(wb_rd_addr), .wb_rd_we(wb_rd_we), .wb_rd_data(wb_rd_data),
        .bus_err(bus_err), .misalign(misalign)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_txn(input logic [1:0] op, input logic [2:0] f3, input logic [4:0] rd,
                           input logic rdwe, input logic [XLEN-1:0] rdat,
                           input logic [ADDR_W-1:0] addr, input logic [XLEN-1:0] sdat,
                           input int ack_dly, input logic [XLEN-1:0] rram);
        bit is_mem, is_st, illegal, mis, go, acked;
        int nbytes, lane, ncyc;
        logic [63:0] mask, v;
        logic [ADDR_W-1:0] e_addr;
        logic [NB-1:0]     e_be;
        logic [XLEN-1:0]   e_wd, e_ld;

        // ---- reference model ----
        is_mem  = (op == 2'b01) || (op == 2'b10);
        is_st   = (op == 2'b10);
        nbytes  = 1 << f3[1:0];
        illegal = (f3[1:0] == 2'b11 && XLEN == 32) || (f3 == 3'b111) ||
                  (is_st && f3[2:1] == 2'b11);
        mis     = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
        mis     = is_mem && !illegal && (addr % nbytes != 0);
`endif
        go      = is_mem && !illegal && !mis;
        lane    = int'(addr % NB);
        lane    = lane - (lane % nbytes);
        e_addr  = ADDR_W'(addr - (addr % NB));
        e_be    = NB'(((64'd1 << nbytes) - 64'd1) << lane);
        e_wd    = XLEN'(64'(sdat) << (8 * lane));
        mask    = (nbytes == 8) ? '1 : ((64'd1 << (8 * nbytes)) - 64'd1);
        v       = (64'(rram) >> (8 * lane)) & mask;
        if (!f3[2] && v[8 * nbytes - 1]) v = v | ~mask;
        e_ld    = v[XLEN-1:0];

        // ---- drive ----
        @(negedge clk);
        check_val("pulse_wb_valid", 64'(wb_valid), 64'd0);
        check_val("pulse_bus_err", 64'(bus_err), 64'd0);
        check_val("ready_idle", 64'(ready_out), 64'd1);
        valid_in = 1'b1; mem_op_in = op; funct3_in = f3; rd_addr_in = rd; rd_we_in = rdwe;
        rd_data_in = rdat; mem_addr_in = addr; store_data_in = sdat;
        ram_ack = 1'($urandom_range(0, 1));   // an ack while idle must be ignored
        ram_rdata = XLEN'($urandom);
        @(negedge clk);
        valid_in = 1'b0; ram_ack = 1'b0;
        mem_op_in = 2'($urandom); funct3_in = 3'($urandom); mem_addr_in = ADDR_W'($urandom);
        store_data_in = XLEN'($urandom); rd_addr_in = 5'($urandom);

        if (go) begin
            acked = (TO == 0) || (ack_dly < TO);
            ncyc  = acked ? ack_dly + 1 : TO;
            for (int i = 0; i < ncyc; i++) begin
                check_val("req_high", 64'(ram_req), 64'd1);
                check_val("ready_stall", 64'(ready_out), 64'd0);
                check_val("ram_we", 64'(ram_we), 64'(is_st));
                check_val("ram_addr", 64'(ram_addr), 64'(e_addr));
                check_val("ram_be", 64'(ram_be), 64'(e_be));
                if (is_st) check_val("ram_wdata", 64'(ram_wdata), 64'(e_wd));
                check_val("wb_early", 64'(wb_valid), 64'd0);
                if (acked && i == ack_dly) begin
                    ram_ack = 1'b1; ram_rdata = rram;
                end
                @(negedge clk);
                ram_ack = 1'b0; ram_rdata = XLEN'($urandom);
            end
            check_val("req_dropped", 64'(ram_req), 64'd0);
            check_val("wb_valid", 64'(wb_valid), 64'd1);
            check_val("wb_rd_addr", 64'(wb_rd_addr), 64'(rd));
            check_val("bus_err", 64'(bus_err), 64'(!acked));
            if (!acked) begin
                check_val("to_rd_we", 64'(wb_rd_we), 64'd0);
            end else if (is_st) begin
                check_val("st_rd_we", 64'(wb_rd_we), 64'd0);
                check_val("st_rd_data", 64'(wb_rd_data), 64'd0);
            end else begin
                check_val("ld_rd_we", 64'(wb_rd_we), 64'(rdwe));
                check_val("ld_rd_data", 64'(wb_rd_data), 64'(e_ld));
            end
        end else begin
            check_val("no_req", 64'(ram_req), 64'd0);
            check_val("wb_valid", 64'(wb_valid), 64'd1);
            check_val("wb_rd_addr", 64'(wb_rd_addr), 64'(rd));
            check_val("bus_err", 64'(bus_err), 64'd0);
            check_val("misalign", 64'(misalign), 64'(mis));
            if (!is_mem) begin
                check_val("alu_rd_we", 64'(wb_rd_we), 64'(rdwe));
                check_val("alu_rd_data", 64'(wb_rd_data), 64'(rdat));
            end else begin
                check_val("rej_rd_we", 64'(wb_rd_we), 64'd0);
            end
        end
    endtask

    initial begin
        reset = 1'b1; valid_in = 1'b0; mem_op_in = '0; funct3_in = '0; rd_addr_in = '0;
        rd_we_in = 1'b0; rd_data_in = '0; mem_addr_in = '0; store_data_in = '0;
        ram_ack = 1'b0; ram_rdata = '0;
        repeat (2) @(negedge clk);
        check_val("rst_ram_req", 64'(ram_req), 64'd0);
        check_val("rst_ram_we", 64'(ram_we), 64'd0);
        check_val("rst_ram_addr", 64'(ram_addr), 64'd0);
        check_val("rst_ram_be", 64'(ram_be), 64'd0);
        check_val("rst_ram_wdata", 64'(ram_wdata), 64'd0);
        check_val("rst_wb_valid", 64'(wb_valid), 64'd0);
        check_val("rst_wb_rd_addr", 64'(wb_rd_addr), 64'd0);
        check_val("rst_wb_rd_we", 64'(wb_rd_we), 64'd0);
        check_val("rst_wb_rd_data", 64'(wb_rd_data), 64'd0);
        check_val("rst_bus_err", 64'(bus_err), 64'd0);
        check_val("rst_misalign", 64'(misalign), 64'd0);
        check_val("rst_ready", 64'(ready_out), 64'd1);
        reset = 1'b0;

        // directed cases
        run_txn(2'b00, 3'b000, 5'd5, 1'b1, 32'h1234, 32'h0, 32'h0, 0, 32'h0);          // ALU pass
        run_txn(2'b01, 3'b000, 5'd7, 1'b1, 32'h0, 32'h103, 32'h0, 2, 32'h80FF_0000);   // LB
        run_txn(2'b10, 3'b001, 5'd2, 1'b1, 32'h0, 32'h202, 32'hABCD, 0, 32'h0);       // SH
        run_txn(2'b01, 3'b010, 5'd9, 1'b1, 32'h0, 32'h100, 32'h0, 99, 32'h0);         // timeout
        run_txn(2'b01, 3'b010, 5'd9, 1'b1, 32'h0, 32'h104, 32'h0, TO - 1, 32'h5A5A_A5A5); // ack at limit
        run_txn(2'b01, 3'b011, 5'd4, 1'b1, 32'h0, 32'h100, 32'h0, 0, 32'h0);          // LD illegal
        run_txn(2'b10, 3'b110, 5'd4, 1'b1, 32'h0, 32'h100, 32'h1, 0, 32'h0);          // store 11x illegal
        run_txn(2'b01, 3'b010, 5'd3, 1'b1, 32'h0, 32'h102, 32'h0, 1, 32'h1122_3344);  // LW 0x102
        run_txn(2'b01, 3'b101, 5'd6, 1'b1, 32'h0, 32'h1FE, 32'h0, 0, 32'h8001_7FFF);  // LHU
        run_txn(2'b11, 3'b010, 5'd8, 1'b1, 32'hCAFE, 32'h0, 32'h0, 0, 32'h0);         // op 11

        // randomized
        for (int n = 0; n < 300; n++) begin
            run_txn(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 5'($urandom),
                    1'($urandom), XLEN'($urandom), ADDR_W'($urandom), XLEN'($urandom),
                    int'($urandom_range(0, TO + 1)), XLEN'($urandom));
        end

        // reset while a request is outstanding
        @(negedge clk);
        valid_in = 1'b1; mem_op_in = 2'b01; funct3_in = 3'b010; mem_addr_in = 32'h40;
        rd_addr_in = 5'd1; rd_we_in = 1'b1;
        @(negedge clk);
        valid_in = 1'b0;
        check_val("mid_req_high", 64'(ram_req), 64'd1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_val("mid_rst_req", 64'(ram_req), 64'd0);
        check_val("mid_rst_ready", 64'(ready_out), 64'd1);
        @(negedge clk);
        reset = 1'b0;
        ram_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_val("mid_rst_no_wb", 64'(wb_valid), 64'd0);
            check_val("mid_rst_no_req", 64'(ram_req), 64'd0);
        end
        ram_ack = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Parametrised memory-access stage sitting between EX/MEM and WB in the RISC-V pipeline. Successor to the combinational LW/SW-only stage: supports all RV32I/RV64I load/store widths with byte enables and sign/zero extension, a multi-cycle RAM request/acknowledge handshake with pipeline stall, an acknowledge timeout, and optional misalignment trapping. All write-back outputs are registered.

## Interface
Parameters:
- XLEN, 32, data/register width; 32 or 64 only.
- ADDR_W, 32, byte-address width.
- ACK_TIMEOUT, 15, max cycles waiting for ram_ack before bus error; 0 disables timeout.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- valid_in  in  1  EX/MEM holds a valid instruction.
- ready_out  out  1  stage can accept; ~ready_out is the upstream stall.
- mem_op_in  in  2  00 none, 01 load, 10 store, 11 treated as none.
- funct3_in  in  3  RISC-V width/sign field.
- rd_addr_in  in  5  destination register.
- rd_we_in  in  1  destination write enable.
- rd_data_in  in  XLEN  ALU result for non-memory ops.
- mem_addr_in  in  ADDR_W  effective byte address.
- store_data_in  in  XLEN  store data, right-aligned.
- ram_req  out  1  RAM request, held until ack.
- ram_we  out  1  1 = write.
- ram_addr  out  ADDR_W  address with low log2(XLEN/8) bits zero.
- ram_be  out  XLEN/8  byte-lane enables.
- ram_wdata  out  XLEN  lane-shifted store data.
- ram_ack  in  1  RAM completes request this cycle.
- ram_rdata  in  XLEN  read data, valid when ram_ack.
- wb_valid  out  1  one-cycle write-back pulse.
- wb_rd_addr  out  5  write-back register.
- wb_rd_we  out  1  write-back enable.
- wb_rd_data  out  XLEN  write-back data.
- bus_err  out  1  one-cycle pulse on timeout.
- misalign  out  1  one-cycle pulse on misaligned access (macro only).

## Operation
- States: IDLE, ACCESS. ready_out = (state == IDLE).
- Accept on rising edge with valid_in & ready_out; inputs captured into internal registers.
- Non-memory op (mem_op none/11): stays IDLE; wb_* = captured rd fields, wb_valid=1 next cycle.
- Load/store: go to ACCESS; ram_req=1, ram_we=store, ram_addr/ram_be/ram_wdata from captured regs; timeout counter cleared.
- Lane = addr[log2(XLEN/8)-1:0]. Size from funct3[1:0]: 00 byte, 01 half, 10 word, 11 dword (XLEN=64 only). ram_be = size mask << lane; ram_wdata = store_data << (8*lane).
- Load: data = ram_rdata >> (8*lane), truncated to size; funct3[2]=0 sign-extend, 1 zero-extend to XLEN.
- Illegal funct3 (011 with XLEN=32, 111, 11x for stores): no RAM access, wb_valid pulse with wb_rd_we=0.
- Store: wb_valid pulses, wb_rd_we=0, wb_rd_data=0.
- ACCESS with ram_ack: capture result, ram_req drops next edge, return IDLE, wb_valid=1 next cycle.
- ACCESS without ack: counter increments; when count reaches ACK_TIMEOUT: drop ram_req, bus_err=1 and wb_valid=1 with wb_rd_we=0 next cycle, return IDLE.

## Timing
- Reset (async): state IDLE, counter 0; ram_req, ram_we, ram_addr, ram_be, ram_wdata, wb_valid, wb_rd_addr, wb_rd_we, wb_rd_data, bus_err, misalign all 0; ready_out=1.
- Reset mid-ACCESS: ram_req falls immediately; transaction abandoned, no write-back.
- Non-memory latency: 1 cycle, throughput 1/cycle.
- Memory latency: ram_req high from cycle after accept; ack allowed in first req cycle; wb_valid the cycle after ack; minimum 2 cycles accept-to-wb, throughput 1 per 2 cycles.
- ram_req, ram_addr, ram_be, ram_wdata, ram_we stable while ram_req high.
- ram_ack ignored in IDLE. Ack coinciding with timeout: ack wins.
- wb_valid, bus_err, misalign are single-cycle pulses.

## Configuration
- MEM_MISALIGN_TRAP_EN defined: half with addr[0]≠0, word with addr[1:0]≠0, dword with addr[2:0]≠0 make no RAM request; next cycle misalign=1, wb_valid=1, wb_rd_we=0; stays IDLE.
- Undefined: misalign port tied 0; address bits below access size forced to zero (naturally aligned access).

## Test plan
- XLEN=32, ALU op rd=5, data 0x1234 -> next cycle wb_valid=1, wb_rd_addr=5, wb_rd_data=0x1234, no ram_req.
- LB addr 0x103, ram_rdata 0x80FF_0000, ack after 3 cycles -> ram_addr 0x100, ram_be 0b1000, ready_out low 3 cycles, wb_rd_data 0xFFFF_FF80.
- SH addr 0x202, data 0xABCD -> ram_we=1, ram_be 0b1100, ram_wdata 0xABCD_0000, wb_rd_we=0.
- XLEN=64, LWU addr 0x14, ram_rdata 0xF000_0001_0000_0000 -> wb_rd_data 0x0000_0000_F000_0001.
- ACK_TIMEOUT=4, no ack -> ram_req high 4 cycles, bus_err pulse, wb_rd_we=0; reset asserted mid-ACCESS in rerun -> ram_req 0 immediately, no wb_valid.
- With MEM_MISALIGN_TRAP_EN, LW addr 0x102 -> no ram_req, misalign=1 and wb_valid=1 one cycle after accept.
